// File: rtl/fa_bist_checker.sv
// -----------------------------------------------------------------------------
// fa_bist_checker
//
// Built-in self-test engine for a single-bit full adder. When start is
// accepted, it drives the 8 input combinations {a,b,cin} = 000..111 in order.
// It holds each one for SETTLE_CYCLES cycles and then samples sum/carry for
// one cycle, comparing them against the arithmetic result. It reports:
//   - pass/fail
//   - a saturating error count
//   - the first failing vector
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..255)
//   ERR_W         : width of err_count; saturates at 2**ERR_W-1
//
// Optional feature
//   FA_BIST_STOP_ON_FAIL_EN : when defined, the first mismatch ends the sweep
//                             immediately (err_count=1, remaining vectors
//                             skipped). Undefined: all 8 vectors are checked.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (aborts a sweep)
//   start      in   one-cycle sweep request; ignored while busy
//   a,b,cin    out  registered adder operands
//   sum,carry  in   adder response, sampled only in the check cycle
//   busy       out  sweep in progress
//   done       out  sweep complete; held until next accepted start or reset
//   pass       out  done and no mismatches
//   err_count  out  number of mismatching vectors (saturating)
//   fail_valid out  at least one mismatch recorded
//   fail_vec   out  {a,b,cin} of the first mismatching vector
// -----------------------------------------------------------------------------
module fa_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_vec;
  logic [7:0]       r_cnt;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [2:0]       r_fail_vec;

  logic             w_exp_sum;
  logic             w_exp_carry;
  logic             w_mismatch;
  logic             w_last;
  logic [ERR_W-1:0] w_err_inc;

  assign w_exp_sum   = r_vec[2] ^ r_vec[1] ^ r_vec[0];
  assign w_exp_carry = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_mismatch  = (sum != w_exp_sum) || (carry != w_exp_carry);
  assign w_last      = (r_vec == 3'b111);
  assign w_err_inc   = (r_err == '1) ? r_err : r_err + ERR_ONE;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
`ifdef FA_BIST_STOP_ON_FAIL_EN
        if (w_mismatch || w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_SETTLE;
        end
`else
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_SETTLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: vector, settle counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_vec        <= '0;
            r_cnt        <= CNT_RELOAD;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= w_err_inc;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= r_vec;
            end
          end
          // Advance only when another vector follows; on completion the
          // last checked vector stays on a/b/cin.
          if (w_next == S_SETTLE) begin
            r_vec <= r_vec + 3'd1;
            r_cnt <= CNT_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs (Moore, from registered state)
  always_comb begin
    busy       = (r_state == S_SETTLE) || (r_state == S_CHECK);
    done       = (r_state == S_DONE);
    pass       = (r_state == S_DONE) && (r_err == '0);
    a          = r_vec[2];
    b          = r_vec[1];
    cin        = r_vec[0];
    err_count  = r_err;
    fail_valid = r_fail_valid;
    fail_vec   = r_fail_vec;
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
module tb_fa_bist_checker;

  localparam int S0 = 3;
  localparam int E0 = 4;
  localparam int S1 = 1;
  localparam int E1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic          a0, b0, c0, sum0, carry0, busy0, done0, pass0, fv0;
  logic [E0-1:0] err0;
  logic [2:0]    fvec0;
  logic          a1, b1, c1, sum1, carry1, busy1, done1, pass1, fv1;
  logic [E1-1:0] err1;
  logic [2:0]    fvec1;

  int         fault_mode = 0;
  logic [7:0] flip_s = '0;
  logic [7:0] flip_c = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Adder under test, with injectable faults. Returns {carry,sum}.
  function automatic logic [1:0] adder_out(input logic [2:0] v, input int mode,
                                           input logic [7:0] fs, input logic [7:0] fc);
    int t;
    logic [1:0] r;
    t = int'(v[2]) + int'(v[1]) + int'(v[0]);
    r = 2'(t);
    case (mode)
      1: r[1] = 1'b0;
      2: r[0] = ~r[0];
      3: begin
        r[0] = r[0] ^ fs[v];
        r[1] = r[1] ^ fc[v];
      end
      default: ;
    endcase
    return r;
  endfunction

  assign {carry0, sum0} = adder_out({a0, b0, c0}, fault_mode, flip_s, flip_c);
  assign {carry1, sum1} = adder_out({a1, b1, c1}, fault_mode, flip_s, flip_c);

  fa_bist_checker #(.SETTLE_CYCLES(S0), .ERR_W(E0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(c0),
    .sum(sum0), .carry(carry0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
  );

  fa_bist_checker #(.SETTLE_CYCLES(S1), .ERR_W(E1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(c1),
    .sum(sum1), .carry(carry1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int s_busy, s_done, s_pass, s_err, s_fv, s_fvec, s_abc;

  task automatic sample(input int inst);
    if (inst == 0) begin
      s_busy = int'(busy0); s_done = int'(done0); s_pass = int'(pass0);
      s_err = int'(err0); s_fv = int'(fv0); s_fvec = int'(fvec0);
      s_abc = int'({a0, b0, c0});
    end else begin
      s_busy = int'(busy1); s_done = int'(done1); s_pass = int'(pass1);
      s_err = int'(err1); s_fv = int'(fv1); s_fvec = int'(fvec1);
      s_abc = int'({a1, b1, c1});
    end
  endtask

  task automatic drive_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else           start1 = v;
  endtask

  // One full sweep on one instance, compared against an arithmetic reference.
  task automatic run_sweep(input int inst, input int mode, input bit mid_pulse, input string tag);
    int s, emax, nchk, nfail, first, good, exp_err, exp_lat, edges, busy_bad;
    logic [1:0] got;
    s     = (inst == 0) ? S0 : S1;
    emax  = (inst == 0) ? (1 << E0) - 1 : (1 << E1) - 1;
    fault_mode = mode;
    nchk = 0; nfail = 0; first = -1;
    for (int v = 0; v < 8; v++) begin
      good = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      got  = adder_out(3'(v), mode, flip_s, flip_c);
      nchk++;
      if (int'(got) != good) begin
        nfail++;
        if (first < 0) first = v;
`ifdef FA_BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    exp_err = (nfail > emax) ? emax : nfail;
    exp_lat = nchk * (s + 1);

    @(negedge clk);
    drive_start(inst, 1'b1);
    @(posedge clk);
    #1 drive_start(inst, 1'b0);
    @(negedge clk);
    sample(inst);
    check({tag, ".start_busy"}, s_busy, 1);
    check({tag, ".start_done"}, s_done, 0);
    check({tag, ".start_abc"}, s_abc, 0);
    check({tag, ".start_err"}, s_err, 0);
    check({tag, ".start_fv"}, s_fv, 0);

    edges = 0; busy_bad = 0;
    while (s_done == 0 && edges <= exp_lat + 20) begin
      if (s_busy != 1) busy_bad = 1;
      if (mid_pulse && edges == 5) drive_start(inst, 1'b1);
      @(posedge clk);
      edges++;
      #1 drive_start(inst, 1'b0);
      @(negedge clk);
      sample(inst);
    end
    check({tag, ".latency"}, edges, exp_lat);
    check({tag, ".busy_held"}, busy_bad, 0);
    check({tag, ".busy_end"}, s_busy, 0);
    check({tag, ".err"}, s_err, exp_err);
    check({tag, ".fv"}, s_fv, (nfail > 0) ? 1 : 0);
    check({tag, ".fvec"}, s_fvec, (first < 0) ? 0 : first);
    check({tag, ".pass"}, s_pass, (nfail == 0) ? 1 : 0);
    check({tag, ".abc"}, s_abc, nchk - 1);
    repeat (3) @(negedge clk);
    sample(inst);
    check({tag, ".hold_done"}, s_done, 1);
    check({tag, ".hold_abc"}, s_abc, nchk - 1);
    check({tag, ".hold_err"}, s_err, exp_err);
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sample(i);
      check($sformatf("rst%0d.busy", i), s_busy, 0);
      check($sformatf("rst%0d.done", i), s_done, 0);
      check($sformatf("rst%0d.pass", i), s_pass, 0);
      check($sformatf("rst%0d.err", i), s_err, 0);
      check($sformatf("rst%0d.abc", i), s_abc, 0);
    end

    for (int i = 0; i < 2; i++) begin
      run_sweep(i, 0, 1'b0, $sformatf("good%0d", i));
      run_sweep(i, 1, 1'b0, $sformatf("c_sa0_%0d", i));
      run_sweep(i, 2, 1'b0, $sformatf("s_inv%0d", i));
      run_sweep(i, 1, 1'b1, $sformatf("midpulse%0d", i));
      run_sweep(i, 0, 1'b0, $sformatf("restart%0d", i));
    end

    for (int k = 0; k < 12; k++) begin
      flip_s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      flip_c = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      run_sweep(k % 2, 3, ($urandom_range(0, 1) == 1), $sformatf("rand%0d", k));
    end

    // Reset in the middle of a sweep, while vector 100 is driven.
    fault_mode = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    guard = 0;
    @(negedge clk);
    sample(0);
    while (s_abc != 4 && guard < 200) begin
      @(negedge clk);
      sample(0);
      guard++;
    end
    check("midrst.reach_vec4", s_abc, 4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    sample(0);
    check("midrst.busy", s_busy, 0);
    check("midrst.done", s_done, 0);
    check("midrst.pass", s_pass, 0);
    check("midrst.err", s_err, 0);
    check("midrst.fv", s_fv, 0);
    check("midrst.fvec", s_fvec, 0);
    check("midrst.abc", s_abc, 0);
    run_sweep(0, 0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
